// File: rtl/pc_unit_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pc_unit_if : control/status bundle between fetch control and pc_unit  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface pc_unit_if #(
  parameter int AW        = 16,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic          stall;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          call;
  logic [AW-1:0] ras_push_addr;
  logic          ret;
  logic          halt;

  logic [AW-1:0] pc;
  logic [AW-1:0] pc_plus;
  logic [CW-1:0] ras_count;
  logic          ras_empty;
  logic          ras_full;
  logic          ras_underflow;
  logic          halted;

  modport master (
    output stall, branch_taken, branch_target, call, ras_push_addr, ret, halt,
    input  pc, pc_plus, ras_count, ras_empty, ras_full, ras_underflow, halted
  );

  modport slave (
    input  stall, branch_taken, branch_target, call, ras_push_addr, ret, halt,
    output pc, pc_plus, ras_count, ras_empty, ras_full, ras_underflow, halted
  );
endinterface
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pc_unit : fetch PC with branch/return/stall/halt arbitration and RAS   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module pc_unit #(
  parameter int AW        = 16,
  parameter int INC       = 2,
  parameter int RESET_VEC = 0,
  parameter int RAS_DEPTH = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  pc_unit_if.slave  bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] c_INC       = AW'(INC);
  localparam logic [AW-1:0] c_RESET_PC  = AW'(RESET_VEC);
  localparam logic [CW-1:0] c_RAS_DEPTH = CW'(RAS_DEPTH);
  localparam logic [PW-1:0] c_PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] c_CNT_ONE   = CW'(1);

  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0] r_top;
  logic [CW-1:0] r_count;
  logic          r_underflow;
  logic          r_halted;

  logic          w_call;
  logic          w_ret;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_uflow;
  logic          w_halt_req;
  logic [AW-1:0] w_pc_plus;
  logic [AW-1:0] w_top_addr;
  logic [AW-1:0] w_pc_nxt;
  logic [PW-1:0] w_top_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_wr_en;
  logic [PW-1:0] w_wr_ptr;

  assign w_call     = bus.call & ~r_halted;
  assign w_ret      = bus.ret  & ~r_halted;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_RAS_DEPTH);
  assign w_pop      = w_ret & ~w_empty;
  assign w_uflow    = w_ret &  w_empty;
  assign w_halt_req = bus.halt & ~bus.branch_taken & ~r_halted;
  assign w_pc_plus  = r_pc + c_INC;
  assign w_top_addr = r_ras[r_top];

  // Halt freezes the PC on the edge it is taken; only a branch outranks it.
  always_comb begin
    w_pc_nxt = r_pc;
    if (r_halted) begin
      w_pc_nxt = r_pc;
    end else if (bus.branch_taken) begin
      w_pc_nxt = bus.branch_target;
    end else if (w_halt_req) begin
      w_pc_nxt = r_pc;
    end else if (w_pop) begin
      w_pc_nxt = w_top_addr;
    end else if (w_uflow || bus.stall) begin
      w_pc_nxt = r_pc;
    end else begin
      w_pc_nxt = w_pc_plus;
    end
  end

  // Call+ret on a non-empty stack swaps the top entry in place.
  always_comb begin
    w_top_nxt   = r_top;
    w_count_nxt = r_count;
    w_wr_en     = 1'b0;
    w_wr_ptr    = r_top;
    if (w_call && w_pop) begin
      w_wr_en  = 1'b1;
      w_wr_ptr = r_top;
    end else if (w_call) begin
      w_wr_en   = 1'b1;
      w_wr_ptr  = r_top + c_PTR_ONE;
      w_top_nxt = r_top + c_PTR_ONE;
      if (!w_full) begin
        w_count_nxt = r_count + c_CNT_ONE;
      end
    end else if (w_pop) begin
      w_top_nxt   = r_top - c_PTR_ONE;
      w_count_nxt = r_count - c_CNT_ONE;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= c_RESET_PC;
      r_top       <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_top   <= w_top_nxt;
      r_count <= w_count_nxt;
      if (w_uflow) begin
        r_underflow <= 1'b1;
      end
      if (w_halt_req) begin
        r_halted <= 1'b1;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (w_wr_en) begin
      r_ras[w_wr_ptr] <= bus.ras_push_addr;
    end
  end

  assign bus.pc            = r_pc;
  assign bus.pc_plus       = w_pc_plus;
  assign bus.ras_count     = r_count;
  assign bus.ras_empty     = w_empty;
  assign bus.ras_full      = w_full;
  assign bus.ras_underflow = r_underflow;
  assign bus.halted        = r_halted;
endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_pc_unit : directed scoreboard bench for pc_unit                    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_pc_unit;
  localparam int AW = 16;
  localparam int D  = 4;

  typedef struct {
    string       name;
    logic [38:0] v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic e_uf;
  logic e_halt;
  exp_t sb[$];
  event ev_async;

  pc_unit_if #(.AW(AW), .RAS_DEPTH(D)) bus ();

  pc_unit #(.AW(AW), .INC(2), .RESET_VEC(0), .RAS_DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected observable state: {pc, pc_plus, count, empty, full, underflow, halted}
  function automatic logic [38:0] pack(input logic [15:0] pc, input logic [2:0] cnt);
    logic [15:0] pp;
    pp = pc + 16'd2;
    return {pc, pp, cnt, (cnt == 3'd0), (cnt == 3'd4), e_uf, e_halt};
  endfunction

  function automatic void push_exp(input string name, input logic [15:0] pc, input logic [2:0] cnt);
    exp_t e;
    e.name = name;
    e.v    = pack(pc, cnt);
    sb.push_back(e);
  endfunction

  task automatic step(input string name, input logic st, input logic br, input logic [15:0] tgt,
                      input logic cl, input logic rt, input logic [15:0] pa, input logic hl,
                      input logic [15:0] e_pc, input logic [2:0] e_cnt);
    @(posedge clk);
    #1;
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.call          = cl;
    bus.ret           = rt;
    bus.ras_push_addr = pa;
    bus.halt          = hl;
    push_exp(name, e_pc, e_cnt);
  endtask

  task automatic idle_inputs();
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.call          = 1'b0;
    bus.ret           = 1'b0;
    bus.ras_push_addr = '0;
    bus.halt          = 1'b0;
  endtask

  task automatic async_reset(input string name);
    @(posedge clk);
    #2;
    idle_inputs();
    rst_n  = 1'b0;
    e_uf   = 1'b0;
    e_halt = 1'b0;
    push_exp(name, 16'h0000, 3'd0);
    -> ev_async;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_exp({name, "_rel"}, 16'h0002, 3'd0);
  endtask

  // Monitor: pops one expectation per update event and compares.
  always begin
    @(negedge clk or ev_async);
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      logic [38:0] act;
      e   = sb.pop_front();
      act = {bus.pc, bus.pc_plus, bus.ras_count, bus.ras_empty, bus.ras_full,
             bus.ras_underflow, bus.halted};
      n_tests++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got pc=%h pc_plus=%h cnt=%0d emp=%b full=%b uf=%b halt=%b, expected pc=%h pc_plus=%h cnt=%0d emp=%b full=%b uf=%b halt=%b",
                 e.name, act[38:23], act[22:7], act[6:4], act[3], act[2], act[1], act[0],
                 e.v[38:23], e.v[22:7], e.v[6:4], e.v[3], e.v[2], e.v[1], e.v[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    e_uf    = 1'b0;
    e_halt  = 1'b0;
    rst_n   = 1'b0;
    idle_inputs();

    // Reset state, checked before any clock edge.
    #2;
    push_exp("reset", 16'h0000, 3'd0);
    -> ev_async;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_exp("run0", 16'h0002, 3'd0);
    step("run1", 0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0004, 3'd0);
    step("run2", 0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0006, 3'd0);

    async_reset("midrun_rst");
    for (int i = 2; i <= 8; i++) begin
      step("seq", 0, 0, 16'h0, 0, 0, 16'h0, 0, 16'(2 * i), 3'd0);
    end

    for (int i = 0; i < 3; i++) begin
      step("stall", 1, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0010, 3'd0);
    end
    step("stall_br", 1, 1, 16'h0100, 0, 0, 16'h0, 0, 16'h0100, 3'd0);

    step("push_a", 0, 0, 16'h0, 1, 0, 16'h0A00, 0, 16'h0102, 3'd1);
    step("push_b", 0, 0, 16'h0, 1, 0, 16'h0B00, 0, 16'h0104, 3'd2);
    step("push_c", 0, 0, 16'h0, 1, 0, 16'h0C00, 0, 16'h0106, 3'd3);
    step("ret_c", 0, 0, 16'h0, 0, 1, 16'h0, 0, 16'h0C00, 3'd2);
    step("ret_b", 0, 0, 16'h0, 0, 1, 16'h0, 0, 16'h0B00, 3'd1);
    step("ret_a", 0, 0, 16'h0, 0, 1, 16'h0, 0, 16'h0A00, 3'd0);
    e_uf = 1'b1;
    step("ret_uflow", 0, 0, 16'h0, 0, 1, 16'h0, 0, 16'h0A00, 3'd0);

    step("push1", 1, 0, 16'h0, 1, 0, 16'h0001, 0, 16'h0A00, 3'd1);
    step("push2", 1, 0, 16'h0, 1, 0, 16'h0002, 0, 16'h0A00, 3'd2);
    step("push3", 1, 0, 16'h0, 1, 0, 16'h0003, 0, 16'h0A00, 3'd3);
    step("push4", 1, 0, 16'h0, 1, 0, 16'h0004, 0, 16'h0A00, 3'd4);
    step("push5_full", 1, 0, 16'h0, 1, 0, 16'h0005, 0, 16'h0A00, 3'd4);
    step("ret5", 1, 0, 16'h0, 0, 1, 16'h0, 0, 16'h0005, 3'd3);
    step("ret4", 1, 0, 16'h0, 0, 1, 16'h0, 0, 16'h0004, 3'd2);
    step("ret3", 1, 0, 16'h0, 0, 1, 16'h0, 0, 16'h0003, 3'd1);
    step("ret2", 1, 0, 16'h0, 0, 1, 16'h0, 0, 16'h0002, 3'd0);

    step("push300", 1, 0, 16'h0, 1, 0, 16'h0300, 0, 16'h0002, 3'd1);
    step("callret", 0, 0, 16'h0, 1, 1, 16'h0400, 0, 16'h0300, 3'd1);
    step("ret400", 0, 0, 16'h0, 0, 1, 16'h0, 0, 16'h0400, 3'd0);
    step("callret_empty", 0, 0, 16'h0, 1, 1, 16'h0500, 0, 16'h0400, 3'd1);
    step("ret500", 0, 0, 16'h0, 0, 1, 16'h0, 0, 16'h0500, 3'd0);
    step("ex_call", 0, 1, 16'h0800, 1, 0, 16'h0900, 0, 16'h0800, 3'd1);
    step("ex_ret", 0, 0, 16'h0, 0, 1, 16'h0, 0, 16'h0900, 3'd0);

    step("br_fffe", 0, 1, 16'hFFFE, 0, 0, 16'h0, 0, 16'hFFFE, 3'd0);
    step("wrap", 0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0000, 3'd0);

    step("halt_br", 0, 1, 16'h001E, 0, 0, 16'h0, 1, 16'h001E, 3'd0);
    step("to_20", 0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0020, 3'd0);
    e_halt = 1'b1;
    step("halt", 0, 0, 16'h0, 0, 0, 16'h0, 1, 16'h0020, 3'd0);
    step("halt_hold", 0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0020, 3'd0);
    step("halt_br_ign", 0, 1, 16'h0100, 0, 0, 16'h0, 0, 16'h0020, 3'd0);
    step("halt_ret_ign", 0, 0, 16'h0, 0, 1, 16'h0, 0, 16'h0020, 3'd0);
    step("halt_call_ign", 0, 0, 16'h0, 1, 0, 16'h0700, 0, 16'h0020, 3'd0);

    async_reset("halt_clear");
    step("post_rst", 0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0004, 3'd0);

    @(posedge clk);
    #1;
    idle_inputs();
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
